// File: rtl/pipe_latch_hs_if.sv
// Handshake bundle between two pipeline stages and the inter-stage latch.
// The master side is the surrounding pipeline (upstream producer plus
// downstream consumer); the slave side is the latch itself.
interface pipe_latch_hs_if #(
   parameter int PC_W    = 12,
   parameter int INSTR_W = 12,
   parameter int SET_W   = 4
);
   logic               in_valid;
   logic               in_ready;
   logic [PC_W-1:0]    in_pc;
   logic [INSTR_W-1:0] in_instr;
   logic [SET_W-1:0]   in_instr_set;
   logic               out_valid;
   logic               out_ready;
   logic [PC_W-1:0]    out_pc;
   logic [INSTR_W-1:0] out_instr;
   logic [SET_W-1:0]   out_instr_set;

   modport master (
      output in_valid, in_pc, in_instr, in_instr_set, out_ready,
      input  in_ready, out_valid, out_pc, out_instr, out_instr_set
   );

   modport slave (
      input  in_valid, in_pc, in_instr, in_instr_set, out_ready,
      output in_ready, out_valid, out_pc, out_instr, out_instr_set
   );
endinterface

// File: rtl/pipe_latch_hs.sv
// Handshaked inter-stage latch: DEPTH-entry circular buffer carrying
// {pc, instr, instr_set}, with flush and a saturating stall counter.
// in_ready / out_valid come from the registered count only, so there is
// no combinational path from in_valid, out_ready or flush to them.
module pipe_latch_hs #(
   parameter int PC_W    = 12,
   parameter int INSTR_W = 12,
   parameter int SET_W   = 4,
   parameter int DEPTH   = 2,
   parameter int CNT_W   = 16
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         flush,
   pipe_latch_hs_if.slave               bus,
   output logic [$clog2(DEPTH+1)-1:0]   occupancy,
   output logic [CNT_W-1:0]             stall_cnt
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int OCC_W = $clog2(DEPTH + 1);

   typedef logic [PTR_W-1:0] ptr_t;

   logic [PC_W-1:0]    pc_mem  [DEPTH];
   logic [INSTR_W-1:0] instr_mem [DEPTH];
   logic [SET_W-1:0]   set_mem [DEPTH];

   ptr_t             wptr;
   ptr_t             rptr;
   logic [OCC_W-1:0] count;
   logic             full;
   logic             empty;
   logic             push;
   logic             pop;

   // Pointers wrap explicitly so DEPTH need not be a power of two.
   function automatic ptr_t ptr_inc(input ptr_t p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + ptr_t'(1);
   endfunction

   // Stall counter holds at all-ones instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
      return (&c) ? c : c + CNT_W'(1);
   endfunction

   assign full  = (count == OCC_W'(DEPTH));
   assign empty = (count == '0);
   assign push  = bus.in_valid && !full && !flush;
   assign pop   = !empty && bus.out_ready && !flush;

   assign bus.in_ready      = !full;
   assign bus.out_valid     = !empty;
   assign bus.out_pc        = empty ? '0 : pc_mem[rptr];
   assign bus.out_instr     = empty ? '0 : instr_mem[rptr];
   assign bus.out_instr_set = empty ? '0 : set_mem[rptr];
   assign occupancy         = count;

   // Pointer and count bookkeeping; flush empties the buffer, rst wins over all.
   always_ff @(posedge clk) begin
      if (rst) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else if (flush) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (push) wptr <= ptr_inc(wptr);
         if (pop)  rptr <= ptr_inc(rptr);
         if (push && !pop)
            count <= count + OCC_W'(1);
         else if (pop && !push)
            count <= count - OCC_W'(1);
      end
   end

   // Entry storage; flush leaves contents alone since the count hides them.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            pc_mem[i]    <= '0;
            instr_mem[i] <= '0;
            set_mem[i]   <= '0;
         end
      end else if (push) begin
         pc_mem[wptr]    <= bus.in_pc;
         instr_mem[wptr] <= bus.in_instr;
         set_mem[wptr]   <= bus.in_instr_set;
      end
   end

   // Count cycles where the head is offered but not taken; flush cycles excluded.
   always_ff @(posedge clk) begin
      if (rst)
         stall_cnt <= '0;
      else if (!empty && !bus.out_ready && !flush)
         stall_cnt <= sat_inc(stall_cnt);
   end

endmodule
